// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard responder for the 0xe0000000 dmem window: receives device-to-host
// frames, buffers valid scan codes in a FIFO and serves CPU loads with a one-cycle stall.
module ps2_kbd_ctrl #(
    parameter int          FIFO_AW    = 4,
    parameter int          FILTER_LEN = 8,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        kbd_sel,
    input  logic        dmem_read_in,
    input  logic        reg_sel,
    output logic [31:0] kbd_data_out,
    output logic        kbd_stall
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FCW   = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    // Input conditioning
    logic [1:0]     clk_sync;
    logic [1:0]     data_sync;
    logic           filt;
    logic [FCW-1:0] filt_cnt;
    logic           fall;
    logic           ps2_d;

    assign ps2_d = data_sync[1];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // The filtered clock only follows the pin after FILTER_LEN matching samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt     <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt     <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= filt;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    // Receive FSM
    state_t      state, state_nxt;
    logic [3:0]  bitcnt;
    logic [9:0]  shreg;
    logic [15:0] tcnt;
    logic        push_req;
    logic        err_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !ps2_d) state_nxt = RECV;
            end
            RECV: begin
                if (tcnt == TIMEOUT) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else if (fall && bitcnt == 4'd9) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (shreg[9] && (^shreg[8:0])) push_req = 1'b1;
                else                           err_set  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // After ten shifts: [7:0] data, [8] parity, [9] stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt <= '0;
            shreg  <= '0;
            tcnt   <= '0;
        end else begin
            case (state)
                RECV: begin
                    if (fall) begin
                        shreg  <= {ps2_d, shreg[9:1]};
                        bitcnt <= bitcnt + 4'd1;
                        tcnt   <= '0;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                CHECK: begin
                    bitcnt <= '0;
                    tcnt   <= '0;
                end
                default: begin
                    bitcnt <= '0;
                    shreg  <= '0;
                    tcnt   <= '0;
                end
            endcase
        end
    end

    // Scan-code FIFO
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty, full;
    logic               access, served, fire;
    logic               pop, do_push, ovf_set, clr;
    logic               frame_err, overflow;
    logic [4:0]         cnt5;

    assign empty   = (count == '0);
    assign full    = (count == (FIFO_AW+1)'(DEPTH));
    assign access  = kbd_sel & dmem_read_in;
    assign kbd_stall = access & ~served;
    assign fire    = kbd_stall;
    assign pop     = fire & ~reg_sel & ~empty;
    assign clr     = fire & reg_sel;
    assign do_push = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;
    assign cnt5    = 5'(count);

    // NOTE: the storage array is deliberately not reset; the pointers and count
    // define which entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Read handshake; a same-cycle sticky event beats the status-read clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            served       <= 1'b0;
            frame_err    <= 1'b0;
            overflow     <= 1'b0;
            kbd_data_out <= '0;
        end else begin
            served    <= access;
            frame_err <= err_set | (frame_err & ~clr);
            overflow  <= ovf_set | (overflow & ~clr);
            if (fire) begin
                if (reg_sel)
                    kbd_data_out <= {19'b0, cnt5, 4'b0, overflow, frame_err, full, ~empty};
                else
                    kbd_data_out <= {23'b0, ~empty, empty ? 8'h00 : mem[rd_ptr]};
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a bit-banged PS/2 device drives frames, reads push
// their expected response into a scoreboard queue that a separate monitor drains.
module tb_ps2_kbd_ctrl;

    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk, ps2_data;
    logic        kbd_sel, dmem_read_in, reg_sel;
    logic [31:0] kbd_data_out;
    logic        kbd_stall;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q [$];
    logic        stall_prev;

    ps2_kbd_ctrl #(
        .FIFO_AW   (4),
        .FILTER_LEN(8),
        .TIMEOUT   (16'd3000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .kbd_sel     (kbd_sel),
        .dmem_read_in(dmem_read_in),
        .reg_sel     (reg_sel),
        .kbd_data_out(kbd_data_out),
        .kbd_stall   (kbd_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of a frame; optionally a short low glitch in one bit's high phase.
    task automatic ps2_send(input logic [7:0] b, input logic bad_par, input int nbits,
                            input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (i == glitch_bit) begin
                wait_cycles(5);
                ps2_clk = 1'b0;
                wait_cycles(6);
                ps2_clk = 1'b1;
                wait_cycles(HALF - 11);
            end else begin
                wait_cycles(HALF);
            end
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cycles(HALF);
    endtask

    task automatic do_read(input logic sel, input logic [31:0] exp, input int hold);
        int stalls;
        stalls = 0;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        kbd_sel = 1'b1; dmem_read_in = 1'b1; reg_sel = sel;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (kbd_stall) stalls++;
            @(posedge clk); #1;
        end
        check("read_held_value", kbd_data_out, exp);
        kbd_sel = 1'b0; dmem_read_in = 1'b0; reg_sel = 1'b0;
        check("stall_cycles", 32'(stalls), 32'd1);
        wait_cycles(2);
    endtask

    // Monitor: the negedge after a stall cycle shows the freshly registered response.
    initial begin
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL read_unexpected: got 0x%08h with no expected entry", kbd_data_out);
                end else begin
                    check("read_response", kbd_data_out, exp_q.pop_front());
                end
            end
            stall_prev = kbd_stall;
        end
    end

    initial begin
        rst = 1'b0;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        kbd_sel = 1'b0; dmem_read_in = 1'b0; reg_sel = 1'b0;
        wait_cycles(3);
        check("reset_data_out", kbd_data_out, 32'h0);
        check("reset_stall", 32'(kbd_stall), 32'h0);
        rst = 1'b1;
        wait_cycles(5);

        // Single frame, then read it and read the now-empty FIFO
        ps2_send(8'h1C, 1'b0, 11, -1);
        do_read(1'b0, 32'h0000011C, 1);
        do_read(1'b0, 32'h00000000, 1);

        // Parity error: sticky frame_err, cleared by the status read
        ps2_send(8'h1C, 1'b1, 11, -1);
        do_read(1'b1, 32'h00000004, 1);
        do_read(1'b1, 32'h00000000, 1);

        // Fill to 16 and overflow with 0xF0
        for (int i = 0; i < 16; i++) ps2_send(8'(i), 1'b0, 11, -1);
        ps2_send(8'hF0, 1'b0, 11, -1);
        do_read(1'b1, 32'h0000100B, 1);
        for (int i = 0; i < 16; i++) do_read(1'b0, 32'h00000100 + 32'(i), 1);
        do_read(1'b0, 32'h00000000, 1);

        // Long-held access: one stall, one pop
        ps2_send(8'h5A, 1'b0, 11, -1);
        do_read(1'b0, 32'h0000015A, 6);
        do_read(1'b1, 32'h00000000, 1);

        // Partial frame aborted by timeout, next frame intact
        ps2_send(8'h00, 1'b0, 5, -1);
        wait_cycles(3200);
        ps2_send(8'h29, 1'b0, 11, -1);
        do_read(1'b1, 32'h00000105, 1);
        do_read(1'b0, 32'h00000129, 1);

        // Sub-filter glitch inside a frame is ignored
        ps2_send(8'h3A, 1'b0, 11, 5);
        do_read(1'b0, 32'h0000013A, 1);

        // Reset in the middle of a frame with a byte already queued
        ps2_send(8'h11, 1'b0, 11, -1);
        ps2_send(8'h22, 1'b0, 6, -1);
        rst = 1'b0;
        #1;
        check("midframe_reset_data_out", kbd_data_out, 32'h0);
        check("midframe_reset_stall", 32'(kbd_stall), 32'h0);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(5);
        do_read(1'b1, 32'h00000000, 1);

        wait_cycles(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Memory-mapped responder for the keyboard region (0xe0000000 window), filling the dmem read path that the CPU-side address redirector leaves open. Receives PS/2 device-to-host frames, checks framing and parity, and buffers scan codes in a FIFO. Serves CPU loads from that FIFO with a single-cycle stall handshake. Runs on ui_clk (the core clock), alongside the data cache and loader.

Parameters:
FIFO_AW, 4, log2 of scan-code FIFO depth (16 entries)
FILTER_LEN, 8, consecutive equal samples required to accept a ps2_clk level change
TIMEOUT, 16'd50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted

Ports:
clk  input  1  core clock (ui_clk)
rst  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock from pin, asynchronous
ps2_data  input  1  raw PS/2 data from pin, asynchronous
kbd_sel  input  1  decoded dmem_addr[29:26]==4'he
dmem_read_in  input  1  CPU load request
reg_sel  input  1  dmem_addr[0]: 0 = data register, 1 = status register
kbd_data_out  output  32  registered read response
kbd_stall  output  1  stall request to pipeline, ORed into mem_stall by the parent

Behaviour:
- Reset (rst low, async):
  - FIFO is emptied and pointers/count are zeroed.
  - FSM goes to IDLE; bit counter, shift register and timeout counter are cleared.
  - Sticky flags are cleared.
  - kbd_data_out = 0, kbd_stall = 0.
  - A frame in flight when reset hits is discarded.
- Input conditioning:
  - 2-flop synchronizer on ps2_clk and ps2_data.
  - Filtered clock changes level only after FILTER_LEN consecutive synchronized samples at the new level; shorter glitches are ignored.
  - fall = filtered clock 1->0, lasting one clk cycle. Data is sampled on fall.
- Receive FSM, states IDLE / RECV / CHECK:
  - IDLE: on fall with data=0 (start bit), go to RECV with bitcnt=0. On fall with data=1, stay in IDLE and ignore it.
  - RECV: on each fall, shift data in LSB first; bitcnt 0-7 are data, 8 is parity, 9 is stop. After the stop bit, go to CHECK.
  - CHECK (1 cycle): the frame is valid when stop==1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Valid: push the byte, then go to IDLE.
    - Invalid: set frame_err, drop the byte, then go to IDLE.
  - Timeout counter runs in RECV and is reset on every fall. When it reaches TIMEOUT: set frame_err, go to IDLE, discard partial data.
- FIFO, depth 2**FIFO_AW:
  - Push when full: byte dropped, overflow set.
  - Push and pop in the same cycle: both occur and count is unchanged, including when full (the pop frees the slot).
  - Pop when empty: no pointer change.
  - Pointers wrap modulo depth; count is FIFO_AW+1 bits.
- Read handshake:
  - access = kbd_sel & dmem_read_in.
  - served is a flag set at the clock edge ending the first access cycle; it clears when access deasserts.
  - kbd_stall = access & ~served, so exactly one stall cycle per access regardless of how long the request is held.
  - On the clock edge ending that stall cycle:
    - reg_sel=0: kbd_data_out <= {23'b0, ~empty, empty ? 8'h00 : head}; pop if not empty.
    - reg_sel=1: kbd_data_out <= {19'b0, count (zero-extended to 5 bits at FIFO_AW=4), 4'b0, overflow, frame_err, full, ~empty}. frame_err and overflow are cleared in the same edge. A sticky event in that same cycle wins: the flag stays set.
  - kbd_data_out holds its value until the next served access.
  - An access held N cycles causes exactly one pop or clear.
- Writes to the keyboard window are ignored; the block has no write port.

Test Plan:
1. Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) -> FIFO count 1. Read reg_sel=0 -> kbd_stall high for exactly 1 cycle, kbd_data_out=0x0000011C. A second read -> 0x00000000.
2. Frame 0x1C with parity 1 -> no push. Status read -> 0x00000004. A second status read -> 0x00000000.
3. Send 0x00..0x0F, then 0xF0 -> status read = 0x0000100B (count 16, overflow, full, not-empty). Sixteen data reads -> 0x100..0x10F in order; 0xF0 is never returned.
4. dmem_read_in held 6 cycles with one byte 0x5A queued -> exactly one stall cycle, one pop; kbd_data_out=0x0000015A for the remainder; count 0 afterwards.
5. Start bit plus 4 data bits, then ps2_clk idle high for TIMEOUT cycles -> frame_err=1, FSM in IDLE. The next complete frame 0x29 is received intact as 0x129.
6. ps2_clk low glitch of FILTER_LEN-2 cycles mid-frame -> no bit sampled, frame decodes correctly. Assert rst low mid-frame -> kbd_data_out=0, kbd_stall=0 immediately; status after release = 0x00000000.
